// File: rtl/outpkt_header.sv
// Transmit framer for packet protocol v1: header, header checksum,
// payload pass-through and data checksum onto the host byte stream.
module outpkt_header #(
    parameter int VERSION = 1,
    parameter int PKT_MAX_LEN = 65536,
    parameter int PKT_MAX_TYPE = 3,
    localparam int PKT_LEN_MSB = $clog2(PKT_MAX_LEN + 1) - 1,
    localparam int PKT_TYPE_MSB = $clog2(PKT_MAX_TYPE + 1) - 1
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  pkt_start,
    input  logic [PKT_TYPE_MSB:0] pkt_type,
    input  logic [15:0]           pkt_id,
    input  logic [PKT_LEN_MSB:0]  pkt_len,
    output logic                  pkt_start_ack,
    input  logic [7:0]            din,
    input  logic                  din_empty,
    output logic                  din_rd_en,
    output logic [7:0]            dout,
    output logic                  dout_valid,
    input  logic                  rd_en,
    output logic                  busy,
    output logic                  pkt_done,
    output logic                  err_pkt_type,
    output logic                  err_pkt_len
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_CSUM_HDR,
        S_DATA,
        S_CSUM_DATA
    } state_t;

    state_t                  state;
    logic [PKT_TYPE_MSB:0]   lat_type;
    logic [15:0]             lat_id;
    logic [PKT_LEN_MSB:0]    lat_len;
    logic [3:0]              byte_idx;
    logic [1:0]              cnt;
    logic [PKT_LEN_MSB:0]    data_cnt;
    logic [31:0]             sum;

    logic [23:0] len24;
    logic [7:0]  hdr_byte;
    logic [31:0] nsum;
    logic [7:0]  csum_byte;
    logic [1:0]  byte_pos;
    logic [31:0] add_word;
    logic        take;
    logic        type_bad;
    logic        len_bad;

    assign len24     = 24'(lat_len);
    assign nsum      = ~sum;
    assign csum_byte = nsum[{cnt, 3'b000} +: 8];
    assign take      = dout_valid & rd_en;
    assign busy      = (state != S_IDLE);
    assign din_rd_en = (state == S_DATA) & rd_en & ~din_empty;

    assign type_bad = (pkt_type == '0) ||
                      (32'(pkt_type) > 32'(PKT_MAX_TYPE));
    assign len_bad  = (pkt_len == '0) ||
                      (32'(pkt_len) > 32'(PKT_MAX_LEN));

    // Both checksums are little-endian word sums, so the byte lane
    // comes from the position within the current section.
    assign byte_pos = (state == S_HDR) ? byte_idx[1:0] : data_cnt[1:0];
    assign add_word = {24'd0, dout} << {byte_pos, 3'b000};

    always_comb begin
        hdr_byte = 8'h00;
        case (byte_idx)
            4'd0:    hdr_byte = 8'(VERSION);
            4'd1:    hdr_byte = 8'(lat_type);
            4'd4:    hdr_byte = len24[7:0];
            4'd5:    hdr_byte = len24[15:8];
            4'd6:    hdr_byte = len24[23:16];
            4'd8:    hdr_byte = lat_id[7:0];
            4'd9:    hdr_byte = lat_id[15:8];
            default: hdr_byte = 8'h00;
        endcase
    end

    always_comb begin
        dout       = 8'h00;
        dout_valid = 1'b0;
        unique case (1'b1)
            (state == S_HDR): begin
                dout       = hdr_byte;
                dout_valid = 1'b1;
            end
            (state == S_CSUM_HDR),
            (state == S_CSUM_DATA): begin
                dout       = csum_byte;
                dout_valid = 1'b1;
            end
            (state == S_DATA): begin
                dout       = din;
                dout_valid = ~din_empty;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state         <= S_IDLE;
            lat_type      <= '0;
            lat_id        <= '0;
            lat_len       <= '0;
            byte_idx      <= '0;
            cnt           <= '0;
            data_cnt      <= '0;
            sum           <= '0;
            pkt_start_ack <= 1'b0;
            pkt_done      <= 1'b0;
            err_pkt_type  <= 1'b0;
            err_pkt_len   <= 1'b0;
        end else begin
            pkt_start_ack <= 1'b0;
            pkt_done      <= 1'b0;
            case (state)
                S_IDLE: begin
                    // The requester still holds pkt_start during the
                    // ack cycle, so that cycle must not re-accept.
                    if (pkt_start && !pkt_start_ack) begin
                        pkt_start_ack <= 1'b1;
                        lat_type      <= pkt_type;
                        lat_id        <= pkt_id;
                        lat_len       <= pkt_len;
                        sum           <= '0;
                        if (type_bad) err_pkt_type <= 1'b1;
                        if (len_bad)  err_pkt_len  <= 1'b1;
                        if (!type_bad && !len_bad) begin
                            state    <= S_HDR;
                            byte_idx <= '0;
                        end
                    end
                end
                S_HDR: begin
                    if (take) begin
                        sum <= sum + add_word;
                        if (byte_idx == 4'd9) begin
                            state <= S_CSUM_HDR;
                            cnt   <= '0;
                        end else begin
                            byte_idx <= byte_idx + 4'd1;
                        end
                    end
                end
                S_CSUM_HDR: begin
                    if (take) begin
                        if (cnt == 2'd3) begin
                            sum      <= '0;
                            state    <= S_DATA;
                            data_cnt <= '0;
                        end else begin
                            cnt <= cnt + 2'd1;
                        end
                    end
                end
                S_DATA: begin
                    if (take) begin
                        sum      <= sum + add_word;
                        data_cnt <= data_cnt + 1'b1;
                        if (data_cnt == lat_len - 1'b1) begin
                            state <= S_CSUM_DATA;
                            cnt   <= '0;
                        end
                    end
                end
                S_CSUM_DATA: begin
                    if (take) begin
                        if (cnt == 2'd3) begin
                            sum      <= '0;
                            state    <= S_IDLE;
                            pkt_done <= 1'b1;
                        end else begin
                            cnt <= cnt + 2'd1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/outpkt_header.md
Name: outpkt_header

Overview:
- Transmit-side framer for packet protocol version 1.
- Takes a packet request (type, id, length) and a byte stream of payload data, and emits onto the FPGA→host byte stream:
  - the 10-byte header
  - a 4-byte header checksum
  - the payload, passed through
  - a 4-byte data checksum
- Sits between the application result FIFOs and the output FIFO.
- Its output must be accepted without error by the input-side header parser.

Parameters:
- VERSION, 1, value of header byte 0; must be nonzero.
- PKT_MAX_LEN, 65536, maximum payload bytes; PKT_LEN_MSB = `MSB(PKT_MAX_LEN).
- PKT_MAX_TYPE, 3, highest legal type; PKT_TYPE_MSB = `MSB(PKT_MAX_TYPE).

Ports:
- CLK  in  1  clock.
- RST_N  in  1  asynchronous, active-low reset.
- pkt_start  in  1  request valid; held until pkt_start_ack.
- pkt_type  in  PKT_TYPE_MSB+1  packet type; zero-extended to 8 bits.
- pkt_id  in  16  packet id.
- pkt_len  in  PKT_LEN_MSB+1  payload length in bytes; zero-extended to 24 bits.
- pkt_start_ack  out  1  one-cycle pulse: request consumed (accepted or rejected).
- din  in  8  payload byte (first-word-fall-through source).
- din_empty  in  1  payload source empty.
- din_rd_en  out  1  payload byte consumed.
- dout  out  8  output byte.
- dout_valid  out  1  dout holds a valid byte.
- rd_en  in  1  downstream takes dout when dout_valid & rd_en.
- busy  out  1  state != IDLE.
- pkt_done  out  1  one-cycle pulse after the last checksum byte is taken.
- err_pkt_type, err_pkt_len  out  1 each  sticky error flags; cleared only by reset.

Behaviour:
- Reset (async, RST_N=0):
  - state=IDLE, all counters and sum=0.
  - All outputs 0, including sticky errors.
  - Reset mid-packet truncates the packet; no recovery framing is emitted.
- States: IDLE → HDR → CSUM_HDR → DATA → CSUM_DATA → IDLE.
- IDLE:
  - dout_valid=0.
  - On pkt_start=1: latch type/id/len, pulse pulse pkt_start_ack, sum<=0.
  - Type check: type==0 or type>PKT_MAX_TYPE → err_pkt_type<=1; stay IDLE; nothing emitted.
  - Length check: len==0 or len>PKT_MAX_LEN → err_pkt_len<=1; stay IDLE; nothing emitted.
  - Otherwise → HDR, with byte_idx=0 and dout_valid=1 from the next cycle.
- HDR (byte_idx 0..9):
  - Bytes in order: VERSION, type, 00, 00, len[7:0], len[15:8], len[23:16], 00, id[7:0], id[15:8].
  - The header length field carries pkt_len itself, not pkt_len-1.
  - Each taken byte b at position p=byte_idx[1:0] does sum<=sum+(b<<8p), modulo 2^32. This equals summing little-endian 32-bit words zero-padded at the tail.
  - On byte 9 taken → CSUM_HDR, cnt=0.
- CSUM_HDR / CSUM_DATA:
  - dout=(~sum)[8cnt+7:8cnt], cnt 0..3, little-endian.
  - sum is frozen while these bytes are emitted.
  - After byte 3 is taken: sum<=0.
  - CSUM_HDR → DATA, data_cnt=0.
  - CSUM_DATA → IDLE and pulse pkt_done.
- DATA:
  - dout=din; dout_valid=~din_empty; din_rd_en=rd_en & ~din_empty (combinational).
  - Taken byte: sum += din<<(8*data_cnt[1:0]); data_cnt++.
  - On the byte with data_cnt==len-1 taken → CSUM_DATA.
  - Payload source underrun only stalls the packet.
- Backpressure: while dout_valid & ~rd_en, dout and all state hold unchanged.
- din_rd_en=0 outside DATA.
- pkt_start while busy is ignored: no ack.
- The header checksum and the data checksum are independent; each starts from sum=0.
- No padding bytes are emitted between packets.
- The block sustains 1 byte/cycle with rd_en tied high.

Test Plan:
1. VERSION=1, type=1, id=0x1234, len=4, payload AA BB CC DD, rd_en=1 → expected stream:
   - 01 01 00 00 04 00 00 00 34 12
   - C6 EC FF FF
   - AA BB CC DD
   - 55 44 33 22
   - then pkt_done pulse; 22 bytes on 22 consecutive cycles after ack.
2. len=1, payload 80 → data checksum 7F FF FF FF; len=5, payload 01 00 00 00 02 → data sum 0x00000003, checksum FC FF FF FF.
3. rd_en toggling 1/0 each cycle, plus din_empty=1 for 3 cycles mid-payload → byte sequence identical to scenario 1; dout stable while stalled; no din_rd_en while empty.
4. type=0 → ack pulse, err_pkt_type=1, busy stays 0, no dout_valid. Then len=0, and separately len=PKT_MAX_LEN+1 → err_pkt_len=1.
5. RST_N low during DATA byte 2 → all outputs 0 immediately. The next request produces a full correct packet.
6. Back-to-back requests with pkt_start held high → second header VERSION byte appears the cycle after the first pkt_done. The stream is parsed by the input-side header parser with no error flags.
